// File: rtl/menu_pkg.sv
// Shared constants and types for the menu navigation controller.
//   DEF_OFF_W          default width of one item x-offset (pixel coordinate width)
//   DEF_HIGHLIGHT_OFF  default highlight offset in pixels for the selected item
//   MENU_PONG          item index that starts the game
//   MENU_CREDITS       item index that shows the credits
//   dir_e              rotation direction of a decoded quadrature event
package menu_pkg;

   localparam int DEF_OFF_W         = 10;
   localparam int DEF_HIGHLIGHT_OFF = 30;

   localparam int MENU_PONG    = 0;
   localparam int MENU_CREDITS = 1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/menu_nav_quad_decoder.sv
// Rotary encoder front end: synchronises rota/rotb, detects quadrature
// events and their direction, and divides events into selection steps.
//   clock      system clock
//   reset      asynchronous active-low reset
//   rota/rotb  raw encoder channels (asynchronous)
//   lock       1 = discard events and hold the accumulator at zero
//   step_up    one-cycle pulse: one selection step upward
//   step_down  one-cycle pulse: one selection step downward
//
// acc_dir   | meaning
// ----------+---------------------------------------------------
// DIR_UP    | acc_cnt counts consecutive upward events
// DIR_DOWN  | acc_cnt counts consecutive downward events
module quad_decoder
   import menu_pkg::*;
#(
   parameter int STEP_DIV = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic rota,
   input  logic rotb,
   input  logic lock,
   output logic step_up,
   output logic step_down
);

   localparam logic [2:0] DIV = 3'(STEP_DIV);

   logic [2:0] qa;
   logic [2:0] qb;
   logic       quad_evt;
   dir_e       evt_dir;
   dir_e       acc_dir;
   logic [2:0] acc_cnt;
   logic [2:0] acc_inc;

   // Exactly one channel changed between the two oldest samples.
   assign quad_evt = qa[2] ^ qa[1] ^ qb[2] ^ qb[1];
   assign evt_dir  = (qa[2] ^ qb[1]) ? DIR_UP : DIR_DOWN;

   // A reversal restarts the count at 1; a cleared count also restarts at 1.
   always_comb begin
      acc_inc = 3'd1;
      if (evt_dir == acc_dir && acc_cnt != 3'd0) begin
         acc_inc = acc_cnt + 3'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         qa        <= '0;
         qb        <= '0;
         acc_cnt   <= '0;
         acc_dir   <= DIR_UP;
         step_up   <= 1'b0;
         step_down <= 1'b0;
      end else begin
         qa        <= {qa[1:0], rota};
         qb        <= {qb[1:0], rotb};
         step_up   <= 1'b0;
         step_down <= 1'b0;
         if (lock) begin
            acc_cnt <= '0;
         end else if (quad_evt) begin
            acc_dir <= evt_dir;
            if (acc_inc == DIV) begin
               acc_cnt   <= '0;
               step_up   <= (evt_dir == DIR_UP);
               step_down <= (evt_dir == DIR_DOWN);
            end else begin
               acc_cnt <= acc_inc;
            end
         end
      end
   end

endmodule

// File: rtl/menu_nav_ctrl.sv
// Parametrised menu navigation controller.
// Turns encoder rotation into a clamped or wrapping item selection, the
// debounced push button into a one-cycle confirm, and slides each item's
// highlight x-offset toward its target once per video frame.
//   clock         system clock
//   reset         asynchronous active-low reset
//   rota/rotb     encoder channels (asynchronous)
//   push          encoder push button, active-high (asynchronous)
//   lock          1 = ignore rotation and push; offsets keep animating
//   frame_tick    one-cycle pulse per video frame
//   menu_select   currently selected item
//   step_pulse    high for the first cycle menu_select shows a new value
//   confirm       one-cycle pulse on a debounced press
//   confirm_item  selection captured with the press, valid while confirm = 1
//   item_offset   item i x-offset at [i*OFF_W +: OFF_W]
module menu_nav_ctrl
   import menu_pkg::*;
#(
   parameter int NUM_ITEMS     = 4,
   parameter int SEL_W         = 3,
   parameter int WRAP          = 0,
   parameter int STEP_DIV      = 1,
   parameter int OFF_W         = DEF_OFF_W,
   parameter int HIGHLIGHT_OFF = DEF_HIGHLIGHT_OFF,
   parameter int SLIDE_STEP    = 2,
   parameter int DEBOUNCE_CYC  = 250000
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       rota,
   input  logic                       rotb,
   input  logic                       push,
   input  logic                       lock,
   input  logic                       frame_tick,
   output logic [SEL_W-1:0]           menu_select,
   output logic                       step_pulse,
   output logic                       confirm,
   output logic [SEL_W-1:0]           confirm_item,
   output logic [NUM_ITEMS*OFF_W-1:0] item_offset
);

   localparam logic [SEL_W-1:0] LAST_ITEM = SEL_W'(NUM_ITEMS - 1);
   localparam logic [SEL_W-1:0] RST_ITEM  = SEL_W'(MENU_PONG);
   localparam int               DB_W      = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DB_W-1:0]  DB_LOAD   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [OFF_W-1:0] HL_OFF    = OFF_W'(HIGHLIGHT_OFF);
   localparam logic [OFF_W-1:0] SLIDE     = OFF_W'(SLIDE_STEP);

   logic             step_up;
   logic             step_down;
   logic [SEL_W-1:0] sel_nxt;
   logic [2:0]       qp;
   logic             db_state;
   logic [DB_W-1:0]  db_cnt;
   logic             db_rise;

   quad_decoder #(
      .STEP_DIV (STEP_DIV)
   ) u_quad_decoder (
      .clock     (clock),
      .reset     (reset),
      .rota      (rota),
      .rotb      (rotb),
      .lock      (lock),
      .step_up   (step_up),
      .step_down (step_down)
   );

   // A step already in flight when lock rises is dropped as well.
   always_comb begin
      sel_nxt = menu_select;
      if (!lock && step_up) begin
         if (menu_select == LAST_ITEM) begin
            sel_nxt = (WRAP != 0) ? '0 : LAST_ITEM;
         end else begin
            sel_nxt = menu_select + SEL_W'(1);
         end
      end else if (!lock && step_down) begin
         if (menu_select == '0) begin
            sel_nxt = (WRAP != 0) ? LAST_ITEM : '0;
         end else begin
            sel_nxt = menu_select - SEL_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         menu_select <= RST_ITEM;
         step_pulse  <= 1'b0;
      end else begin
         menu_select <= sel_nxt;
         step_pulse  <= (sel_nxt != menu_select);
      end
   end

   // Debounce timer: reloads while the synchronised button matches the
   // debounced state, and the state flips when it expires after
   // DEBOUNCE_CYC consecutive differing samples.
   assign db_rise = qp[2] && !db_state && (db_cnt == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         qp           <= '0;
         db_state     <= 1'b0;
         db_cnt       <= DB_LOAD;
         confirm      <= 1'b0;
         confirm_item <= '0;
      end else begin
         qp <= {qp[1:0], push};
         if (qp[2] == db_state) begin
            db_cnt <= DB_LOAD;
         end else if (db_cnt == '0) begin
            db_state <= qp[2];
            db_cnt   <= DB_LOAD;
         end else begin
            db_cnt <= db_cnt - DB_W'(1);
         end
         // The debouncer runs through lock, so a press held across the
         // release of lock never produces a confirm.
         confirm <= db_rise && !lock;
         if (db_rise && !lock) begin
            confirm_item <= menu_select;
         end
      end
   end

   for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
      logic [OFF_W-1:0] off_q;
      logic [OFF_W-1:0] off_tgt;
      logic [OFF_W-1:0] off_nxt;

      assign off_tgt = (menu_select == SEL_W'(i)) ? HL_OFF : '0;

      // Move by SLIDE, landing exactly on the target instead of overshooting.
      always_comb begin
         off_nxt = off_q;
         if (SLIDE_STEP == 0) begin
            off_nxt = off_tgt;
         end else if (frame_tick) begin
            if (off_q < off_tgt) begin
               off_nxt = ((off_tgt - off_q) > SLIDE) ? off_q + SLIDE : off_tgt;
            end else begin
               off_nxt = ((off_q - off_tgt) > SLIDE) ? off_q - SLIDE : off_tgt;
            end
         end
      end

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            off_q <= '0;
         end else begin
            off_q <= off_nxt;
         end
      end

      assign item_offset[i*OFF_W +: OFF_W] = off_q;
   end

endmodule
